// File: rtl/vsc8541_smi_frame_engine.sv
// vsc8541_smi_frame_engine: Clause-22 MDIO frame engine driven by a clk-synchronous MDC
// Ports: clk, i_reset (async, active-high), i_mdc, i_start/i_rw/i_phyad/i_regad/i_wdata (request),
//        i_mdio_i/o_mdio_o/o_mdio_oe (pad), o_busy, o_done, o_rdata, o_rd_err.
// Optional: define VSC8541_SMI_RD_ERR_EN to sample TA bit 1 of reads and flag an absent PHY on o_rd_err.
module vsc8541_smi_frame_engine #(
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_mdc,
  input  logic        i_start,
  input  logic        i_rw,
  input  logic [4:0]  i_phyad,
  input  logic [4:0]  i_regad,
  input  logic [15:0] i_wdata,
  input  logic        i_mdio_i,
  output logic        o_mdio_o,
  output logic        o_mdio_oe,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_rdata,
  output logic        o_rd_err
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_HDR, S_TA, S_DATA, S_END} state_t;
  // Bit-index of the last bit of each section; the counter runs 0..PREAMBLE_LEN+31.
  localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN - 1);
  localparam logic [5:0] HDR_LAST  = 6'(PREAMBLE_LEN + 13);
  localparam logic [5:0] TA_LAST   = 6'(PREAMBLE_LEN + 15);
  localparam logic [5:0] DATA_LAST = 6'(PREAMBLE_LEN + 31);
  state_t      state, nxt;
  logic        mdc_q, fall, rise, rd, last;
  logic [5:0]  cnt;
  logic [31:0] sr;
  logic [15:0] rsh;
  assign fall = mdc_q & ~i_mdc;
  assign rise = ~mdc_q & i_mdc;
  assign last = fall && state == S_DATA && cnt == DATA_LAST;
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = i_start ? S_WAIT : S_IDLE;
      S_WAIT:  nxt = !fall ? S_WAIT : (PREAMBLE_LEN == 0 ? S_HDR : S_PRE);
      S_PRE:   nxt = fall && cnt == PRE_LAST ? S_HDR : S_PRE;
      S_HDR:   nxt = fall && cnt == HDR_LAST ? S_TA : S_HDR;
      S_TA:    nxt = fall && cnt == TA_LAST ? S_DATA : S_TA;
      S_DATA:  nxt = last ? S_END : S_DATA;
      default: nxt = S_IDLE;
    endcase
  end
  // The preamble is generated from state alone; sr holds ST..DATA and is shifted only
  // once the header starts, so sr[31] is always the bit currently on the wire.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      mdc_q   <= 1'b0;
      cnt     <= '0;
      sr      <= '0;
      rd      <= 1'b0;
      rsh     <= '0;
      o_rdata <= '0;
    end else begin
      mdc_q <= i_mdc;
      if (state == S_IDLE && i_start) begin
        sr <= {2'b01, i_rw ? 2'b10 : 2'b01, i_phyad, i_regad, 2'b10, i_wdata};
        rd <= i_rw;
      end
      if (fall && state == S_WAIT) cnt <= '0;
      else if (fall && state inside {S_PRE, S_HDR, S_TA, S_DATA} && !last) cnt <= cnt + 6'd1;
      if (fall && state inside {S_HDR, S_TA, S_DATA}) sr <= {sr[30:0], 1'b0};
      if (rise && rd && state == S_DATA) rsh <= {rsh[14:0], i_mdio_i};
      if (last && rd) o_rdata <= rsh;
    end
  end
`ifdef VSC8541_SMI_RD_ERR_EN
  logic ta1;
  // A pulled-up TA bit 1 means no PHY answered the read.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      ta1      <= 1'b0;
      o_rd_err <= 1'b0;
    end else begin
      if (state == S_IDLE && i_start) o_rd_err <= 1'b0;
      if (rise && state == S_TA && cnt == TA_LAST) ta1 <= i_mdio_i;
      if (last) o_rd_err <= rd & ta1;
    end
  end
`else
  assign o_rd_err = 1'b0;
`endif
  always_comb begin
    o_busy    = !(state inside {S_IDLE, S_END});
    o_done    = state == S_END;
    o_mdio_oe = state inside {S_PRE, S_HDR} || (state inside {S_TA, S_DATA} && !rd);
    o_mdio_o  = o_mdio_oe && state != S_PRE ? sr[31] : 1'b1;
  end
endmodule

// File: tb/tb_vsc8541_smi_frame_engine.sv
// tb_vsc8541_smi_frame_engine: scoreboard bench for the MDIO frame engine (preamble 32 and 0)
module tb_vsc8541_smi_frame_engine;
  typedef struct {
    int          id;
    int          n;
    logic [63:0] ev;
    logic [63:0] eo;
    logic [15:0] rd;
    logic        re;
    int          f0;
  } item_t;
  logic        clk = 0, rst = 1, mdc = 0, mdio_i = 1, rw = 0, fell = 0, seen = 0;
  logic [1:0]  start = 0, oe, mo, busy, done, rerr;
  logic [4:0]  phyad = 0, regad = 0;
  logic [15:0] wdata = 0, rdata0, rdata1;
  logic [15:0] last_rd [2];
  item_t       sb[$];
  logic        phyq[$];
  logic [1:0]  rec[$];
  int          total = 0, bad = 0, falls = 0, ph = 0;

  vsc8541_smi_frame_engine #(.PREAMBLE_LEN(32)) u0 (
    .clk(clk), .i_reset(rst), .i_mdc(mdc), .i_start(start[0]), .i_rw(rw), .i_phyad(phyad),
    .i_regad(regad), .i_wdata(wdata), .i_mdio_i(mdio_i), .o_mdio_o(mo[0]), .o_mdio_oe(oe[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_rdata(rdata0), .o_rd_err(rerr[0]));
  vsc8541_smi_frame_engine #(.PREAMBLE_LEN(0)) u1 (
    .clk(clk), .i_reset(rst), .i_mdc(mdc), .i_start(start[1]), .i_rw(rw), .i_phyad(phyad),
    .i_regad(regad), .i_wdata(wdata), .i_mdio_i(mdio_i), .o_mdio_o(mo[1]), .o_mdio_oe(oe[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_rdata(rdata1), .o_rd_err(rerr[1]));

  initial forever #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // MDC (period 4 clk), PHY model and scoreboard monitor, all at the falling clk edge.
  initial begin : mon
    int a;
    logic ok;
    item_t it;
    forever begin
      @(negedge clk);
      a = (busy[1] | done[1]) ? 1 : 0;
      if (done[a]) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          it = sb.pop_front();
          while (rec.size() > 0 && rec[0][1] == 1'b0) void'(rec.pop_front());
          ok = rec.size() == it.n;
          for (int k = 0; k < it.n && ok; k++)
            if (rec[k][1] !== it.eo[k] || (it.eo[k] && rec[k][0] !== it.ev[k])) ok = 0;
          chk("frame_bits", ok, 1);
          chk("frame_len", rec.size(), it.n);
          chk("rdata", a ? rdata1 : rdata0, it.rd);
          chk("rd_err", rerr[a], it.re);
          chk("end_pins", {oe[a], mo[a], busy[a]}, 3'b010);
          chk("mdc_periods", falls - it.f0, it.n + 1);
          chk("instance", a, it.id);
          rec.delete();
        end
      end else if (busy == 2'b00) rec.delete();
      if (ph == 1 && busy[a]) rec.push_back({oe[a], mo[a]});
      if (!busy[0]) seen = 0;
      else if (oe[0]) seen = 1;
      fell = ph == 3;
      if (fell) begin
        falls++;
        mdio_i = (seen && !oe[0] && phyq.size() > 0) ? phyq.pop_front() : 1'b1;
      end
      ph = (ph + 1) % 4;
      mdc = ph >= 2;
    end
  end

  task automatic frame(int id, logic r, logic present, logic ta1, logic coincide, logic extra,
                       logic [4:0] pa, logic [4:0] ra, logic [15:0] wd, logic [15:0] rv);
    item_t it;
    logic [13:0] hdr;
    logic [17:0] tail;
    int k, t;
    phyad = pa; regad = ra; wdata = wd; rw = r;
    k = 0; it.ev = '0; it.eo = '0;
    for (int i = 0; i < (id ? 0 : 32); i++) begin it.eo[k] = 1; it.ev[k] = 1; k++; end
    hdr = {2'b01, r ? 2'b10 : 2'b01, pa, ra};
    tail = {2'b10, wd};
    for (int i = 13; i >= 0; i--) begin it.eo[k] = 1; it.ev[k] = hdr[i]; k++; end
    for (int i = 17; i >= 0; i--) begin it.eo[k] = !r; it.ev[k] = tail[i]; k++; end
    it.n = k; it.id = id;
    if (r) last_rd[id] = present ? rv : 16'hFFFF;
    it.rd = last_rd[id];
`ifdef VSC8541_SMI_RD_ERR_EN
    it.re = r && (!present || ta1);
`else
    it.re = 1'b0;
`endif
    phyq.delete();
    if (r && present) begin
      phyq.push_back(ta1);
      for (int i = 15; i >= 0; i--) phyq.push_back(rv[i]);
    end
    if (coincide) begin
      t = 0;
      do begin step(); t++; end while (!fell && t < 8);
    end
    it.f0 = falls;
    sb.push_back(it);
    start[id] = 1;
    step();
    start[id] = 0;
    chk("busy_after_start", busy[id], 1);
    phyad = 5'($urandom); regad = 5'($urandom); wdata = 16'($urandom); rw = 1'($urandom);
    if (extra) begin
      repeat (20) step();
      start[id] = 1; step(); start[id] = 0;
      t = 0;
      do begin step(); t++; end while (!fell && t < 8);
      start[id] = 1; step(); start[id] = 0;
    end
    t = 0;
    while (sb.size() > 0 && t < 3000) begin step(); t++; end
    if (sb.size() > 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    repeat (2) step();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int f0, t;
    last_rd[0] = 0; last_rd[1] = 0;
    repeat (3) step();
    chk("reset_pins0", {oe[0], mo[0], busy[0], done[0], rerr[0]}, 5'b01000);
    chk("reset_pins1", {oe[1], mo[1], busy[1], done[1], rerr[1]}, 5'b01000);
    chk("reset_rdata0", rdata0, 0);
    rst = 0;
    step();
    frame(0, 0, 1, 0, 0, 0, 5'h01, 5'h1F, 16'hA5C3, 16'h0);
    frame(0, 1, 1, 0, 0, 0, 5'h00, 5'h02, 16'h0, 16'h0007);
    frame(0, 0, 1, 0, 0, 0, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0);
    frame(0, 1, 0, 0, 0, 0, 5'h00, 5'h02, 16'h0, 16'h0);
    frame(0, 0, 1, 0, 1, 1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0);
    frame(0, 1, 1, 1, 0, 0, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom));
    phyad = 5'($urandom); regad = 5'($urandom); wdata = 16'($urandom); rw = 0;
    phyq.delete();
    f0 = falls;
    start[0] = 1; step(); start[0] = 0;
    t = 0;
    while (falls - f0 < 52 && t < 1000) begin step(); t++; end
    #2 rst = 1;
    #1 chk("midframe_reset_pins", {oe[0], mo[0], busy[0], done[0]}, 4'b0100);
    step();
    chk("midframe_reset_rdata", rdata0, 0);
    rst = 0;
    last_rd[0] = 0; last_rd[1] = 0;
    step();
    frame(0, 0, 1, 0, 0, 0, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0);
    frame(1, 0, 1, 0, 0, 0, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0);
    frame(1, 0, 1, 0, 1, 1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0);
    for (int i = 0; i < 6; i++)
      frame(0, 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            1'($urandom), 0, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
